// File: rtl/fir_interp_dac.sv
// x4 interpolating 16-tap polyphase low-pass FIR that drives a paced 10-bit DAC word stream.
// One shared MAC walks the four taps of the current phase once per output word period.
module fir_interp_dac #(
    parameter int unsigned DIV = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [9:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [9:0] dac_data,
    output logic       dac_valid,
    output logic       underrun,
    output logic [1:0] phase
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_RES  = CW'(4);

    // Symmetric taps h[0..15]; every phase h[p], h[4+p], h[8+p], h[12+p] sums to 32.
    function automatic logic [4:0] coef(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd15: coef = 5'd1;
            4'd1, 4'd14: coef = 5'd2;
            4'd2, 4'd13: coef = 5'd4;
            4'd3, 4'd12: coef = 5'd6;
            4'd4, 4'd11: coef = 5'd9;
            4'd5, 4'd10: coef = 5'd12;
            4'd6, 4'd9:  coef = 5'd14;
            default:     coef = 5'd16;
        endcase
    endfunction

    logic [9:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [9:0]    d0_q, d0_d, d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    ph_q, ph_d;
    logic [14:0]   acc_q, acc_d;
    logic [9:0]    result_q, result_d;
    logic [9:0]    dac_data_q, dac_data_d;
    logic          dac_valid_q, dac_valid_d;
    logic          underrun_q, underrun_d;
    logic [1:0]    phase_q, phase_d;

    logic [9:0]  tap_data;
    logic [4:0]  tap_coef;
    logic [14:0] product;
    logic [9:0]  rounded;
    logic        handshake;
    logic        last_cycle;

    // Input handshake: a word transfers on any clock edge where in_valid && in_ready.
    // in_ready is simply "holding slot empty" (no same-cycle bypass), so the source
    // must hold in_data stable while in_valid is high and in_ready is low.
    assign in_ready   = !hold_full_q;
    assign handshake  = in_valid && !hold_full_q;
    assign last_cycle = (cnt_q == CNT_LAST);

    always_comb begin
        tap_data = d0_q;
        case (cnt_q[1:0])
            2'd0: tap_data = d0_q;
            2'd1: tap_data = d1_q;
            2'd2: tap_data = d2_q;
            2'd3: tap_data = d3_q;
            default: tap_data = d0_q;
        endcase
    end

    // Tap index 4k+p, with k taken from the cycle counter while the MAC runs.
    assign tap_coef = coef({cnt_q[1:0], ph_q});
    assign product  = 15'(tap_data) * 15'(tap_coef);
    assign rounded  = 10'((acc_q + 15'd16) >> 5);

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        d0_d        = d0_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        d3_d        = d3_q;
        cnt_d       = cnt_q;
        ph_d        = ph_q;
        acc_d       = acc_q;
        result_d    = result_q;
        dac_data_d  = dac_data_q;
        dac_valid_d = 1'b0;
        underrun_d  = 1'b0;
        phase_d     = phase_q;

        if (handshake) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end

        if (!en) begin
            cnt_d = '0;
            ph_d  = '0;
            acc_d = '0;
        end else begin
            cnt_d = last_cycle ? '0 : cnt_q + CW'(1);

            if (cnt_q == '0) begin
                acc_d = product;
            end else if (cnt_q < CNT_RES) begin
                acc_d = acc_q + product;
            end

            if (cnt_q == CNT_RES) begin
                result_d = rounded;
            end

            if (last_cycle) begin
                dac_data_d  = result_q;
                phase_d     = ph_q;
                dac_valid_d = 1'b1;
                ph_d        = ph_q + 2'd1;

                // Frame advance; a missing sample repeats d0, the last consumed value.
                if (ph_q == 2'd3) begin
                    d3_d = d2_q;
                    d2_d = d1_q;
                    d1_d = d0_q;
                    if (hold_full_q) begin
                        d0_d        = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        d0_d       = d0_q;
                        underrun_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            d0_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            d3_q        <= '0;
            cnt_q       <= '0;
            ph_q        <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            dac_data_q  <= '0;
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            phase_q     <= '0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            d0_q        <= d0_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            d3_q        <= d3_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
            underrun_q  <= underrun_d;
            phase_q     <= phase_d;
        end
    end

    assign dac_data  = dac_data_q;
    assign dac_valid = dac_valid_q;
    assign underrun  = underrun_q;
    assign phase     = phase_q;

endmodule

// File: tb/tb_fir_interp_dac.sv
// Bench for fir_interp_dac: queue-fed source, time-indexed interpolation model, per-scenario tasks.
module tb_fir_interp_dac;

    localparam int DIV   = 8;
    localparam int FRAME = 4 * DIV;
    localparam int H[16] = '{1, 2, 4, 6, 9, 12, 14, 16, 16, 14, 12, 9, 6, 4, 2, 1};

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [9:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] dac_data;
    logic       dac_valid;
    logic       underrun;
    logic [1:0] phase;

    fir_interp_dac #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dac_data (dac_data),
        .dac_valid(dac_valid),
        .underrun (underrun),
        .phase    (phase)
    );

    // Clock and reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_total  = 0;
    int hs_count = 0;
    logic [9:0] tx_q[$];

    // Source driver: offers the head of tx_q, pops it on an observed transfer.
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            in_valid = (tx_q.size() > 0);
            in_data  = in_valid ? tx_q[0] : 10'($urandom_range(0, 1023));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && in_valid && in_ready && tx_q.size() > 0) begin
                void'(tx_q.pop_front());
                hs_count++;
            end
        end
    end

    // Reference model: time since the run started picks the output word and its
    // phase; a 4-entry sample history (newest first) gives the filter output.
    logic       m_full    = 1'b0;
    logic [9:0] m_hold    = '0;
    logic [9:0] m_dl[4]   = '{default: '0};
    int         m_t       = 0;
    int         m_p       = 0;
    int         m_sum     = 0;
    logic       m_hs      = 1'b0;
    logic       exp_valid = 1'b0;
    logic       exp_under = 1'b0;
    logic [9:0] exp_data  = '0;
    logic [1:0] exp_phase = '0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_full    = 1'b0;
                m_hold    = '0;
                m_t       = 0;
                exp_valid = 1'b0;
                exp_under = 1'b0;
                exp_data  = '0;
                exp_phase = '0;
                for (int k = 0; k < 4; k++) m_dl[k] = '0;
            end else begin
                m_hs      = in_valid && !m_full;
                exp_valid = 1'b0;
                exp_under = 1'b0;
                if (!en) begin
                    m_t = 0;
                end else begin
                    if (m_t % DIV == DIV - 1) begin
                        m_p   = (m_t / DIV) % 4;
                        m_sum = 0;
                        for (int k = 0; k < 4; k++) m_sum += H[4 * k + m_p] * int'(m_dl[k]);
                        exp_data  = 10'((m_sum + 16) / 32);
                        exp_phase = 2'(m_p);
                        exp_valid = 1'b1;
                        if (m_p == 3) begin
                            m_dl[3] = m_dl[2];
                            m_dl[2] = m_dl[1];
                            m_dl[1] = m_dl[0];
                            if (m_full) begin
                                m_dl[0] = m_hold;
                                m_full  = 1'b0;
                            end else begin
                                exp_under = 1'b1;
                            end
                        end
                    end
                    m_t++;
                end
                if (m_hs) begin
                    m_hold = in_data;
                    m_full = 1'b1;
                end
            end
        end
    end

    logic [14:0] obs_vec;
    logic [14:0] exp_vec;
    assign obs_vec = {in_ready, dac_valid, underrun, phase, dac_data};
    assign exp_vec = {~m_full, exp_valid, exp_under, exp_phase, exp_data};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({dac_valid, underrun, phase, dac_data} !== 14'd0)
            $display("FAIL reset_outputs got %h want 0", {dac_valid, underrun, phase, dac_data});
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        int nv = 0, nu = 0, nz = 0, nph = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL idle_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
            if (dac_valid) begin
                if (phase !== 2'(nv % 4)) nph++;
                if (dac_data !== 10'd0) nz++;
                nv++;
            end
            if (underrun) nu++;
        end
        n_total++;
        if (nv != 12) $display("FAIL idle_strobes got %0d want 12", nv); else n_pass++;
        n_total++;
        if (nu != 3) $display("FAIL idle_underruns got %0d want 3", nu); else n_pass++;
        n_total++;
        if (nz != 0) $display("FAIL idle_nonzero_words got %0d want 0", nz); else n_pass++;
        n_total++;
        if (nph != 0) $display("FAIL idle_phase_order got %0d bad want 0", nph); else n_pass++;
    endtask

    task automatic test_dc();
        int nv = 0, nbad = 0, nu = 0;
        repeat (20) tx_q.push_back(10'd512);
        for (int i = 0; i < 10 * FRAME; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL dc_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
            if (i >= 6 * FRAME) begin
                if (dac_valid) begin
                    nv++;
                    if (dac_data !== 10'd512) nbad++;
                end
                if (underrun) nu++;
            end
        end
        n_total++;
        if (nv != 16) $display("FAIL dc_strobes got %0d want 16", nv); else n_pass++;
        n_total++;
        if (nbad != 0) $display("FAIL dc_level got %0d words off 512 want 0", nbad); else n_pass++;
        n_total++;
        if (nu != 0) $display("FAIL dc_underrun got %0d want 0", nu); else n_pass++;
    endtask

    task automatic test_impulse();
        int imp[16] = '{32, 64, 128, 192, 288, 384, 448, 512, 512, 448, 384, 288, 192, 128, 64, 32};
        logic [9:0] words[$];
        int first = -1;
        rst_n = 1'b0;
        tx_q.delete();
        repeat (2) @(negedge clk);
        tx_q.push_back(10'd1023);
        repeat (24) tx_q.push_back(10'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12 * FRAME; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL impulse_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
            if (dac_valid) words.push_back(dac_data);
        end
        for (int i = 0; i < words.size(); i++) begin
            if (first < 0 && words[i] != 10'd0) first = i;
        end
        n_total++;
        if (first != 4) $display("FAIL impulse_latency got word %0d want word 4", first); else n_pass++;
        if (first >= 0 && first + 20 <= words.size()) begin
            for (int j = 0; j < 20; j++) begin
                n_total++;
                if (int'(words[first + j]) != (j < 16 ? imp[j] : 0))
                    $display("FAIL impulse_word%0d got %0d want %0d", j, words[first + j], (j < 16 ? imp[j] : 0));
                else n_pass++;
            end
        end else begin
            n_total++;
            $display("FAIL impulse_capture got %0d words want at least %0d", words.size(), first + 20);
        end
    endtask

    task automatic test_backpressure();
        int hs0;
        int nrdy = 0;
        tx_q.delete();
        repeat (40) tx_q.push_back(10'($urandom_range(0, 1023)));
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL bp_settle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
        hs0 = hs_count;
        for (int i = 0; i < 8 * FRAME; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL bp_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
            if (in_ready) nrdy++;
        end
        n_total++;
        if (hs_count - hs0 != 8) $display("FAIL bp_handshakes got %0d want 8", hs_count - hs0); else n_pass++;
        n_total++;
        if (nrdy != 8) $display("FAIL bp_ready_cycles got %0d want 8", nrdy); else n_pass++;
    endtask

    task automatic test_en_drop();
        int nv = 0, lat = 0;
        logic [1:0] first_ph = 2'd3;
        for (int i = 0; i < 2 * DIV && (m_t % DIV) != 2; i++) @(negedge clk);
        n_total++;
        if ((m_t % DIV) != 2) $display("FAIL en_align got cnt %0d want 2", m_t % DIV); else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL en_low_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
            if (dac_valid || underrun) nv++;
        end
        n_total++;
        if (nv != 0) $display("FAIL en_low_strobes got %0d want 0", nv); else n_pass++;
        en = 1'b1;
        for (int i = 1; i <= 4 * DIV && lat == 0; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL en_restart_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
            if (dac_valid) begin
                lat      = i;
                first_ph = phase;
            end
        end
        n_total++;
        if (lat != DIV) $display("FAIL en_restart_latency got %0d want %0d", lat, DIV); else n_pass++;
        n_total++;
        if (first_ph !== 2'd0) $display("FAIL en_restart_phase got %0d want 0", first_ph); else n_pass++;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL en_resume_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
    endtask

    task automatic test_underrun_hold();
        logic [9:0] words[$];
        int nu = 0, hs0;
        tx_q.delete();
        repeat (6) tx_q.push_back(10'd700);
        for (int i = 0; i < 12 * FRAME; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL uh_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
            if (dac_valid) words.push_back(dac_data);
            if (i >= 10 * FRAME && underrun) nu++;
        end
        for (int j = 1; j <= 4; j++) begin
            n_total++;
            if (words.size() < j || words[words.size() - j] !== 10'd700)
                $display("FAIL uh_settle_word%0d got %0d want 700", j, (words.size() < j) ? 0 : words[words.size() - j]);
            else n_pass++;
        end
        n_total++;
        if (nu != 2) $display("FAIL uh_pulses got %0d want 2", nu); else n_pass++;
        hs0 = hs_count;
        tx_q.push_back(10'($urandom_range(0, 1023)));
        repeat (2) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL uh_accept_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
        end
        n_total++;
        if (hs_count != hs0 + 1) $display("FAIL uh_accept got %0d handshakes want 1", hs_count - hs0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nv = 0;
        for (int i = 0; i < 2 * DIV && (m_t % DIV) != 3; i++) @(negedge clk);
        n_total++;
        if ((m_t % DIV) != 3) $display("FAIL rst_align got cnt %0d want 3", m_t % DIV); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (dac_data !== 10'd0) $display("FAIL rst_async_data got %0d want 0", dac_data); else n_pass++;
        n_total++;
        if ({dac_valid, underrun, phase} !== 4'd0)
            $display("FAIL rst_async_flags got %h want 0", {dac_valid, underrun, phase});
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL rst_async_ready got %b want 1", in_ready); else n_pass++;
        tx_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            n_total++;
            if (obs_vec !== exp_vec) $display("FAIL rst_resume_cycle t=%0t got %h want %h", $time, obs_vec, exp_vec);
            else n_pass++;
            if (dac_valid) nv++;
        end
        n_total++;
        if (nv != 8) $display("FAIL rst_resume_strobes got %0d want 8", nv); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        test_reset();
        test_idle();
        test_dc();
        test_impulse();
        test_backpressure();
        test_en_drop();
        test_underrun_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_interp_dac.md
Name: fir_interp_dac

Overview:
- Output-side counterpart of the ADC low-pass FIR path.
- Takes 10-bit unsigned samples over a valid/ready handshake and interpolates them x4 with a 16-tap symmetric polyphase low-pass FIR.
- Drives a paced 10-bit DAC word stream, one word every DIV clocks.
- Uses a single time-multiplexed MAC, sequenced by a cycle counter and a phase counter.

Parameters:
- DIV, 8, clocks per DAC output word; legal range >= 6. Input sample rate = output rate / 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  run enable; low = pause and restart phase/cycle sequencing
- in_data  in  10  unsigned input sample
- in_valid  in  1  in_data valid
- in_ready  out  1  holding slot empty; transfer when in_valid && in_ready
- dac_data  out  10  registered interpolated output word
- dac_valid  out  1  one-clock strobe; dac_data is new this cycle
- underrun  out  1  one-clock strobe; a frame started with no fresh sample
- phase  out  2  polyphase index of the current dac_data word

Behaviour:
- Reset is asynchronous, active-low. Cleared on reset:
  - delay line d0..d3 (d0 newest), holding register, hold-full flag
  - cycle counter cnt, phase ph, accumulator, result
  - dac_data=0, dac_valid=0, underrun=0, phase=0
- in_ready = !hold_full (no bypass). A handshake loads the holding register and sets hold_full.
- Coefficients are fixed: h[0..15] = 1,2,4,6,9,12,14,16,16,14,12,9,6,4,2,1.
  - Each phase sums to 32, so DC gain = 1 after >>5.
- Phase p output: y = sum over k=0..3 of h[4k+p]*d_k.
  - Accumulator is 15 bits unsigned (max 1023*32 = 32736; cannot overflow).
  - Result = (acc + 16) >> 5, round half up; max result 1023, so no saturation.
- Frame sequencing while en=1: cnt runs 0..DIV-1 and wraps.
  - cnt=0: acc <= h[p]*d0.
  - cnt=1..3: acc += h[4k+p]*d_k for k=cnt.
  - cnt=4: result <= rounded acc.
  - cnt=DIV-1:
    - dac_data <= result, phase <= ph, dac_valid=1 for one cycle.
    - ph <= ph+1 (mod 4).
- Frame advance, when cnt=DIV-1 and ph=3:
  - hold_full=1: shift the holding register into d0 (d1<=d0 .. d3<=d2) and clear hold_full.
  - hold_full=0: shift the last consumed sample value (register, reset 0) into d0 and pulse underrun for one cycle.
  - A handshake in that same cycle fills the holding register only and is used at the next frame advance.
- Output latency:
  - A sample consumed at frame advance appears as d0 in the next 4 output words.
  - Its first word strobes DIV clocks after the advance.
- en low:
  - Next cycle: cnt=0, ph=0, acc=0, dac_valid=0, underrun=0.
  - Delay line, holding register, dac_data and phase are retained.
  - The input handshake stays active.
  - On en rising, sequencing restarts at phase 0, cnt 0.
- Reset mid-frame aborts the MAC; all state clears and no strobe is emitted.
- Before any input arrives, outputs are 0 and underrun pulses once per frame (every 4*DIV clocks).

Test Plan:
- Reset/idle: en=1, no input, DIV=8 -> dac_valid every 8 clks, dac_data=0, phase 0,1,2,3 repeating; underrun pulse every 32 clks; in_ready=1.
- DC: in_data=512 offered continuously -> after the 4th consumed sample every dac_data=512; no underrun once streaming.
- Impulse: 1023 then 0s, kept ahead of demand -> 8 consecutive words 32,64,128,192,288,384,448,512, then the mirror 512,448,384,288,192,128,64,32, then 0s.
- Backpressure: in_valid held high -> exactly one handshake per 4*DIV clks after the slot first fills; in_ready low between frame advances; no sample lost or duplicated.
- Underrun hold: stream 700 then stop input -> underrun pulses each frame; dac_data settles at 700 (last sample repeated); a new sample is accepted immediately.
- Mid-frame en drop at cnt=2, and rst_n pulse at cnt=3 -> en: no dac_valid while low, restart at phase 0 with cnt 0, delay line intact; rst_n: all outputs 0 immediately (asynchronous).
